// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
//   Bundles the issue, MTHI/MTLO and result signals of the HI/LO
//   multiply/divide unit. Clock and reset stay outside as plain ports.
//
//   Handshake: the unit accepts a request only while busy is low. A start
//   seen with busy low is taken at that edge; start/mthi/mtlo seen while busy
//   is high are dropped, not queued. done pulses for the single cycle in which
//   the new hi/lo are first visible.
//
//   Signals (master = requester, slave = mult_div_unit):
//     start     m->s  issue op on a, b
//     op[1:0]   m->s  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     a[31:0]   m->s  multiplicand / dividend
//     b[31:0]   m->s  multiplier / divisor
//     mthi      m->s  write wdata to HI
//     mtlo      m->s  write wdata to LO
//     wdata     m->s  MTHI/MTLO data
//     busy      s->m  operation in progress
//     done      s->m  result pulse
//     hi, lo    s->m  HI/LO registers
//     dbg_state s->m  FSM state (0 IDLE, 1 RUN, 2 FIN)
// -----------------------------------------------------------------------------
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative 32-bit multiply/divide unit holding the MIPS HI/LO pair.
//   MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one
//   iteration per cycle for 32 cycles; signs are handled by working on
//   magnitudes and correcting the result in FIN. MTHI/MTLO write HI/LO
//   directly while idle.
//
//   Latency: start sampled at E0, iterations at E1..E32, hi/lo/done at E33.
//
//   Optional feature, macro MULDIV_FAST_MULT_EN: MULT/MULTU use a single
//   32x32 array product and go IDLE->FIN; the product is formed at E1 and
//   committed at E2. Divides are unaffected.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    mult_div_unit_if.slave (request, MTHI/MTLO, busy/done, hi/lo,
//            debug state)
// -----------------------------------------------------------------------------
module mult_div_unit (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_op;
  logic [31:0] r_mcand;    // multiplicand magnitude, or divisor magnitude
  logic [63:0] r_acc;      // mult: {partial, multiplier}; div: {rem, quotient}
  logic        r_neg_q;    // negate product / quotient
  logic        r_neg_r;    // negate remainder
  logic        r_div0;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  // control strobes from the output process
  logic        w_load;
  logic        w_iter;
  logic        w_commit;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic        w_fast_pend;

  // ---------------------------------------------------------------------------
  // Operand conditioning at issue
  // ---------------------------------------------------------------------------
  logic        w_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  assign w_signed = ~bus.op[0];
  assign w_abs_a  = (w_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign w_abs_b  = (w_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [32:0] w_div_diff;
  logic [31:0] w_div_rem;
  logic [63:0] w_div_next;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole 65-bit result right by one.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Restoring divide: bring the next dividend bit into the remainder and
  // subtract the divisor if it fits. A zero divisor always "fits", which
  // leaves quotient all ones and remainder equal to the dividend magnitude.
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
  assign w_div_diff  = w_div_shift - {1'b0, r_mcand};
  assign w_div_rem   = w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0];
  assign w_div_next  = {w_div_rem, r_acc[30:0], w_div_ge};

  // ---------------------------------------------------------------------------
  // Sign correction applied at commit
  // ---------------------------------------------------------------------------
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_prod_fix = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quo_fix  = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  // With a zero divisor the remainder is |a| and carries a's sign, so this
  // path also reproduces hi = a for the divide-by-zero case.
  assign w_rem_fix  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
  assign w_res_hi   = r_op[1] ? w_rem_fix : w_prod_fix[63:32];
  assign w_res_lo   = r_op[1] ? (r_div0 ? 32'hFFFF_FFFF : w_quo_fix) : w_prod_fix[31:0];

  // ---------------------------------------------------------------------------
  // Fast multiply option
  // ---------------------------------------------------------------------------
`ifdef MULDIV_FAST_MULT_EN
  logic        r_fast_pend;
  logic [63:0] w_fast_prod;
  assign w_fast_prod = {32'd0, r_mcand} * {32'd0, r_acc[31:0]};
  assign w_fast_pend = r_fast_pend;
`else
  assign w_fast_pend = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef MULDIV_FAST_MULT_EN
          w_next = bus.op[1] ? S_RUN : S_FIN;
`else
          w_next = S_RUN;
`endif
        end
      end
      S_RUN:   if (r_cnt == 6'd31) w_next = S_FIN;
      S_FIN:   if (!w_fast_pend) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (control strobes)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load   = 1'b0;
    w_iter   = 1'b0;
    w_commit = 1'b0;
    w_wr_hi  = 1'b0;
    w_wr_lo  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load  = bus.start;
        // start wins over a simultaneous MTHI/MTLO
        w_wr_hi = ~bus.start & bus.mthi;
        w_wr_lo = ~bus.start & bus.mtlo;
      end
      S_RUN:   w_iter   = 1'b1;
      S_FIN:   w_commit = ~w_fast_pend;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= 2'd0;
      r_mcand <= 32'd0;
      r_acc   <= 64'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_cnt   <= 6'd0;
    end else if (w_load) begin
      r_op    <= bus.op;
      r_mcand <= bus.op[1] ? w_abs_b : w_abs_a;
      r_acc   <= {32'd0, (bus.op[1] ? w_abs_a : w_abs_b)};
      r_neg_q <= w_signed & (bus.a[31] ^ bus.b[31]);
      r_neg_r <= w_signed & bus.op[1] & bus.a[31];
      r_div0  <= bus.op[1] & (bus.b == 32'd0);
      r_cnt   <= 6'd0;
    end else if (w_iter) begin
      r_acc   <= r_op[1] ? w_div_next : w_mul_next;
      r_cnt   <= r_cnt + 6'd1;
    end
`ifdef MULDIV_FAST_MULT_EN
    else if (r_state == S_FIN && r_fast_pend) begin
      r_acc   <= w_fast_prod;
    end
`endif
  end

`ifdef MULDIV_FAST_MULT_EN
  // Extra FIN cycle in which the array product is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fast_pend <= 1'b0;
    end else if (w_load) begin
      r_fast_pend <= ~bus.op[1];
    end else if (r_state == S_FIN) begin
      r_fast_pend <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else begin
      if (w_wr_hi) r_hi <= bus.wdata;
      if (w_wr_lo) r_lo <= bus.wdata;
    end
  end

  // busy/done are registered straight from the next-state decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= w_commit;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Drives mult_div_unit through directed corner cases and randomized ops and
//   compares hi/lo/busy/done against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: {hi, lo} from plain 64-bit arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic int exp_latency(input logic [1:0] op);
    int lat;
    lat = 33;
`ifdef MULDIV_FAST_MULT_EN
    if (!op[1]) lat = 2;
`endif
    return lat;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Issue one op, optionally with MTHI in the same cycle, optionally poking
  // start/MTHI while the unit is busy. Checks timing, stability and result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit with_mthi, input bit poke_busy);
    logic [63:0] exp;
    int          lat;
    int          n;
    bit          seen;
    bit          stable;
    exp = ref_result(op, a, b);
    exp_q.push_back(exp);
    lat = exp_latency(op);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (with_mthi) begin
      bus.mthi  = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);  // E0
    #1;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.a     = $urandom;  // operands are free to change after E0
    bus.b     = $urandom;
    check("busy_after_e0", {63'd0, bus.busy}, 64'd1);
    check("hi_held_e0", {32'd0, bus.hi}, {32'd0, m_hi});
    check("lo_held_e0", {32'd0, bus.lo}, {32'd0, m_lo});

    stable = 1'b1;
    seen   = 1'b0;
    n      = 0;
    while (!seen && n < 40) begin
      if (poke_busy && n == 1) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd9;
        bus.b     = 32'd4;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      #1;
      n++;
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      if (bus.done) seen = 1'b1;
      else if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b1) stable = 1'b0;
    end

    exp = exp_q.pop_front();
    check("done_seen", {63'd0, seen}, 64'd1);
    check("latency", 64'(n), 64'(lat));
    check("stable_while_busy", {63'd0, stable}, 64'd1);
    check("result", {bus.hi, bus.lo}, exp);
    check("busy_at_done", {63'd0, bus.busy}, 64'd0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(posedge clk);
    #1;
    check("done_cleared", {63'd0, bus.done}, 64'd0);
  endtask

  task automatic mt_write(input bit wr_hi, input bit wr_lo, input logic [31:0] d);
    @(negedge clk);
    bus.mthi  = wr_hi;
    bus.mtlo  = wr_lo;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    if (wr_hi) m_hi = d;
    if (wr_lo) m_lo = d;
    check("mt_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    check("mt_lo", {32'd0, bus.lo}, {32'd0, m_lo});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_tests   = 0;
    n_fail    = 0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = 32'd0;

    // reset, then idle
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_hi",    {32'd0, bus.hi}, 64'd0);
    check("rst_lo",    {32'd0, bus.lo}, 64'd0);
    check("rst_busy",  {63'd0, bus.busy}, 64'd0);
    check("rst_done",  {63'd0, bus.done}, 64'd0);
    check("rst_state", {62'd0, bus.dbg_state}, 64'd0);

    // directed corners
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    run_op(2'b11, 32'd100,       32'd0,         1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FF9C, 32'd0,         1'b0, 1'b0);

    // clear HI/LO, then MULTU 2*3 with ignored start/MTHI/MTLO while busy
    mt_write(1'b1, 1'b1, 32'd0);
    run_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b1);
    mt_write(1'b0, 1'b1, 32'h0000_1234);
    mt_write(1'b1, 1'b0, 32'hCAFE_F00D);

    // start and MTHI together: start wins
    run_op(2'b11, 32'd9, 32'd4, 1'b1, 1'b0);

    // randomized ops with biased corners
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 17));
        default: ;
      endcase
      run_op(rop, ra, rb, 1'b0, 1'b0);
    end

    // reset in the middle of a DIVU
    mt_write(1'b1, 1'b1, 32'h5555_AAAA);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'd1000;
    bus.b     = 32'd7;
    @(posedge clk);  // E0
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);  // E1..E9
    #1 reset = 1'b1;
    @(posedge clk);  // E10
    #1;
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    check("midrst_busy",  {63'd0, bus.busy}, 64'd0);
    check("midrst_done",  {63'd0, bus.done}, 64'd0);
    check("midrst_hi",    {32'd0, bus.hi}, {32'd0, m_hi});
    check("midrst_lo",    {32'd0, bus.lo}, {32'd0, m_lo});
    check("midrst_state", {62'd0, bus.dbg_state}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_late_done", {63'd0, bus.done}, 64'd0);
    check("midrst_hi_kept", {32'd0, bus.hi}, 64'd0);

    // unit still works after the abort
    run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
